// File: rtl/frag_pkg.sv
// Shared definitions for the writeback arbiter slice: data width, register
// address type and the grant encoding used by the arbiter.
package frag_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ALU  = 2'd1,
    GRANT_LSU  = 2'd2
  } grant_e;

  // x0 is hardwired to zero: never written, never pending.
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/frag_wb_arbiter_if.sv
// Bundle of writeback, load-issue, operand-lookup and register-file write
// signals. The arbiter takes the slave side.
interface frag_wb_arbiter_if;
  import frag_pkg::*;

  logic             alu_wb_valid;
  logic             alu_wb_ready;
  reg_addr_t        alu_wb_rd;
  logic [XLEN-1:0]  alu_wb_data;

  logic             lsu_wb_valid;
  logic             lsu_wb_ready;
  reg_addr_t        lsu_wb_rd;
  logic [XLEN-1:0]  lsu_wb_data;

  logic             ld_issue_valid;
  logic             ld_issue_ready;
  reg_addr_t        ld_issue_rd;

  logic             flush;

  reg_addr_t        rs1_addr;
  reg_addr_t        rs2_addr;
  logic             rs1_busy;
  logic             rs2_busy;

  logic             RegWrite;
  reg_addr_t        w_addr;
  logic [XLEN-1:0]  w_data;

  modport master (
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output ld_issue_valid, ld_issue_rd,
    output flush, rs1_addr, rs2_addr,
    input  alu_wb_ready, lsu_wb_ready, ld_issue_ready,
    input  rs1_busy, rs2_busy,
    input  RegWrite, w_addr, w_data
  );

  modport slave (
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  ld_issue_valid, ld_issue_rd,
    input  flush, rs1_addr, rs2_addr,
    output alu_wb_ready, lsu_wb_ready, ld_issue_ready,
    output rs1_busy, rs2_busy,
    output RegWrite, w_addr, w_data
  );

endinterface

// File: rtl/frag_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set on load
// issue, cleared on load return, wiped on flush.
module frag_scoreboard
  import frag_pkg::*;
(
  input  logic      sys_clk,
  input  logic      sys_arstn,
  input  logic      flush,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd,
  output logic      issue_ready,
  input  logic      clr_valid,
  input  reg_addr_t clr_rd,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy
);

  // Bit 0 has no storage so x0 can never look pending.
  logic [REG_NUM-1:1] pending_reg;
  logic [REG_NUM-1:0] pending;
  logic               issue_fire;
  logic               clr_fire;

  assign pending = {pending_reg, 1'b0};

  // One outstanding load per rd keeps load writes in issue order.
  assign issue_ready = !pending[issue_rd] || is_zero_reg(issue_rd);
  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign clr_fire    = clr_valid && !flush;

  assign rs1_busy = pending[rs1_addr] && !is_zero_reg(rs1_addr);
  assign rs2_busy = pending[rs2_addr] && !is_zero_reg(rs2_addr);

  genvar gi;
  generate
    for (gi = 1; gi < REG_NUM; gi++) begin : g_pending
      logic set_hit;
      logic clr_hit;
      logic pending_next;

      assign set_hit = issue_fire && (issue_rd == reg_addr_t'(gi));
      assign clr_hit = clr_fire && (clr_rd == reg_addr_t'(gi));
      // A new load to the same rd outranks the return of the old one.
      assign pending_next = flush ? 1'b0 : (set_hit || (pending_reg[gi] && !clr_hit));

      always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
          pending_reg[gi] <= 1'b0;
        end else begin
          pending_reg[gi] <= pending_next;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/frag_wb_arbiter.sv
// Register-file write port owner: arbitrates ALU vs LSU writeback with an
// anti-starvation counter, registers the write, and hosts the load scoreboard.
module frag_wb_arbiter
  import frag_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             sys_clk,
  input  logic             sys_arstn,
  frag_wb_arbiter_if.slave bus
);

  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
  logic             reg_write_reg, reg_write_next;
  reg_addr_t        w_addr_reg, w_addr_next;
  logic [XLEN-1:0]  w_data_reg, w_data_next;

  grant_e           grant;
  reg_addr_t        win_rd;
  logic [XLEN-1:0]  win_data;

  // Loads normally win so the scoreboard drains; ALU wins once it has been
  // refused STARVE_LIMIT cycles in a row.
  always_comb begin
    grant = GRANT_NONE;
    if (bus.lsu_wb_valid && !(bus.alu_wb_valid && starve_cnt_reg == STARVE_MAX)) begin
      grant = GRANT_LSU;
    end else if (bus.alu_wb_valid) begin
      grant = GRANT_ALU;
    end
  end

  assign bus.alu_wb_ready = (grant == GRANT_ALU);
  assign bus.lsu_wb_ready = (grant == GRANT_LSU);

  always_comb begin
    win_rd   = bus.alu_wb_rd;
    win_data = bus.alu_wb_data;
    if (grant == GRANT_LSU) begin
      win_rd   = bus.lsu_wb_rd;
      win_data = bus.lsu_wb_data;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (bus.flush || !bus.alu_wb_valid || grant == GRANT_ALU) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_comb begin
    reg_write_next = (grant != GRANT_NONE) && !is_zero_reg(win_rd);
    w_addr_next    = w_addr_reg;
    w_data_next    = w_data_reg;
    if (reg_write_next) begin
      w_addr_next = win_rd;
      w_data_next = win_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      starve_cnt_reg <= '0;
      reg_write_reg  <= 1'b0;
      w_addr_reg     <= REG_ZERO;
      w_data_reg     <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      reg_write_reg  <= reg_write_next;
      w_addr_reg     <= w_addr_next;
      w_data_reg     <= w_data_next;
    end
  end

  assign bus.RegWrite = reg_write_reg;
  assign bus.w_addr   = w_addr_reg;
  assign bus.w_data   = w_data_reg;

  // Pending bit drops on the same edge RegWrite rises, so the register
  // file's bypass covers the first cycle the operand looks free.
  frag_scoreboard u_scoreboard (
    .sys_clk     (sys_clk),
    .sys_arstn   (sys_arstn),
    .flush       (bus.flush),
    .issue_valid (bus.ld_issue_valid),
    .issue_rd    (bus.ld_issue_rd),
    .issue_ready (bus.ld_issue_ready),
    .clr_valid   (grant == GRANT_LSU),
    .clr_rd      (bus.lsu_wb_rd),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .rs1_busy    (bus.rs1_busy),
    .rs2_busy    (bus.rs2_busy)
  );

endmodule

// File: tb/tb_frag_wb_arbiter.sv
// Directed plus randomized bench for frag_wb_arbiter, checked against a
// rule-level model of grants, starvation, write port and pending loads.
module tb_frag_wb_arbiter;
  import frag_pkg::*;

  localparam int LIMIT = 4;

  logic sys_clk = 1'b0;
  logic sys_arstn = 1'b0;
  always #5 sys_clk = ~sys_clk;

  frag_wb_arbiter_if bus();

  frag_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .sys_clk   (sys_clk),
    .sys_arstn (sys_arstn),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit [31:0]   m_pend;
  int          m_starve;
  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  bit          last_ga, last_gl;
  bit          obs_alu_ready;
  logic [9:0]  alu_pat;
  int          cand[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.alu_wb_valid = 0; bus.alu_wb_rd = 0; bus.alu_wb_data = 0;
    bus.lsu_wb_valid = 0; bus.lsu_wb_rd = 0; bus.lsu_wb_data = 0;
    bus.ld_issue_valid = 0; bus.ld_issue_rd = 0;
    bus.flush = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
  endtask

  task automatic model_reset();
    m_pend = '0; m_starve = 0; e_we = 0; e_addr = '0; e_data = '0;
  endtask

  // Called just after a rising edge with inputs already driven; checks the
  // combinational outputs, crosses one edge, then checks registered outputs.
  task automatic step(input string tag);
    bit a, l, ga, gl, iss_ok, fl, iv;
    logic [4:0]  ar, lr, ir;
    logic [31:0] ad, ld;
    #2;
    a  = bus.alu_wb_valid; ar = bus.alu_wb_rd; ad = bus.alu_wb_data;
    l  = bus.lsu_wb_valid; lr = bus.lsu_wb_rd; ld = bus.lsu_wb_data;
    iv = bus.ld_issue_valid; ir = bus.ld_issue_rd; fl = bus.flush;
    gl = l && !(a && m_starve == LIMIT);
    ga = a && !gl;
    iss_ok = (ir == 0) || !m_pend[ir];
    chk({tag, ".alu_ready"}, bus.alu_wb_ready, ga);
    chk({tag, ".lsu_ready"}, bus.lsu_wb_ready, gl);
    chk({tag, ".issue_ready"}, bus.ld_issue_ready, iss_ok);
    chk({tag, ".rs1_busy"}, bus.rs1_busy, m_pend[bus.rs1_addr]);
    chk({tag, ".rs2_busy"}, bus.rs2_busy, m_pend[bus.rs2_addr]);
    obs_alu_ready = bus.alu_wb_ready;
    last_ga = ga; last_gl = gl;
    @(posedge sys_clk);
    e_we = (ga && ar != 0) || (gl && lr != 0);
    if (ga && ar != 0) begin e_addr = ar; e_data = ad; end
    if (gl && lr != 0) begin e_addr = lr; e_data = ld; end
    if (fl || !a || ga) m_starve = 0;
    else if (m_starve < LIMIT) m_starve++;
    if (fl) m_pend = '0;
    else begin
      if (gl && lr != 0) m_pend[lr] = 1'b0;
      if (iv && iss_ok && ir != 0) m_pend[ir] = 1'b1;
    end
    #1;
    chk({tag, ".RegWrite"}, bus.RegWrite, e_we);
    if (e_we) begin
      chk({tag, ".w_addr"}, bus.w_addr, e_addr);
      chk({tag, ".w_data"}, bus.w_data, e_data);
    end
    chk({tag, ".rs1_busy_post"}, bus.rs1_busy, m_pend[bus.rs1_addr]);
  endtask

  initial begin
    drive_idle();
    model_reset();
    #2;
    chk("reset.RegWrite", bus.RegWrite, 1'b0);
    chk("reset.w_addr", bus.w_addr, 5'd0);
    chk("reset.w_data", bus.w_data, 32'd0);
    chk("reset.rs1_busy", bus.rs1_busy, 1'b0);
    @(posedge sys_clk); #1;
    sys_arstn = 1'b1;

    // ALU alone: accepted at once, written one cycle later.
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 32'hDEAD_BEEF;
    #1;
    chk("alu_only.ready_now", bus.alu_wb_ready, 1'b1);
    step("alu_only");
    chk("alu_only.w_addr5", bus.w_addr, 5'd5);
    chk("alu_only.w_data", bus.w_data, 32'hDEAD_BEEF);
    drive_idle();
    step("idle0");

    // Both valid every cycle: four loads, then the ALU, repeating.
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 5'd10; bus.alu_wb_data = $urandom;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 5'd12; bus.lsu_wb_data = $urandom;
    alu_pat = '0;
    for (int i = 0; i < 10; i++) begin
      step("starve");
      alu_pat[i] = obs_alu_ready;
      if (last_ga) bus.alu_wb_data = $urandom;
      if (last_gl) bus.lsu_wb_data = $urandom;
    end
    chk("starve.pattern", alu_pat, 10'b10_0001_0000);
    drive_idle();
    step("idle1");

    // Load to x7: busy, re-issue blocked, return clears busy as RegWrite rises.
    bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd7;
    step("issue7");
    bus.rs1_addr = 5'd7;
    #1;
    chk("issue7.busy", bus.rs1_busy, 1'b1);
    chk("issue7.reissue_blocked", bus.ld_issue_ready, 1'b0);
    step("reissue7");
    bus.ld_issue_valid = 0;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 5'd7; bus.lsu_wb_data = 32'h0000_0707;
    step("ret7");
    chk("ret7.busy_drop", bus.rs1_busy, 1'b0);
    chk("ret7.RegWrite", bus.RegWrite, 1'b1);
    chk("ret7.w_addr", bus.w_addr, 5'd7);
    drive_idle();

    // x0 traffic is accepted but never writes or becomes pending.
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 5'd0; bus.alu_wb_data = 32'h1234_5678;
    bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd0;
    #1;
    chk("x0.alu_ready", bus.alu_wb_ready, 1'b1);
    chk("x0.issue_ready", bus.ld_issue_ready, 1'b1);
    step("x0");
    chk("x0.no_write", bus.RegWrite, 1'b0);
    chk("x0.not_busy", bus.rs1_busy, 1'b0);
    drive_idle();

    // Load return and new issue to x9 in one cycle: new load stays pending.
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 5'd9; bus.lsu_wb_data = 32'h0909_0909;
    bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd9; bus.rs1_addr = 5'd9;
    step("setclr9");
    chk("setclr9.busy", bus.rs1_busy, 1'b1);
    chk("setclr9.w_addr", bus.w_addr, 5'd9);
    drive_idle();

    // Pending x3/x4 plus partial starvation, then flush clears both.
    bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd3;
    step("issue3");
    bus.ld_issue_rd = 5'd4;
    step("issue4");
    bus.ld_issue_valid = 0; bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd4;
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 5'd10; bus.alu_wb_data = $urandom;
    bus.lsu_wb_valid = 1; bus.lsu_wb_rd = 5'd20; bus.lsu_wb_data = $urandom;
    for (int i = 0; i < 2; i++) begin
      step("prestarve");
      bus.lsu_wb_data = $urandom;
    end
    bus.flush = 1;
    step("flush");
    chk("flush.rs1_busy", bus.rs1_busy, 1'b0);
    chk("flush.rs2_busy", bus.rs2_busy, 1'b0);
    bus.flush = 0;
    bus.lsu_wb_data = $urandom;
    alu_pat = '0;
    for (int i = 0; i < 5; i++) begin
      step("postflush");
      alu_pat[i] = obs_alu_ready;
      if (last_ga) bus.alu_wb_data = $urandom;
      if (last_gl) bus.lsu_wb_data = $urandom;
    end
    chk("postflush.pattern", alu_pat, 10'b00_0001_0000);
    drive_idle();
    step("idle2");

    // Randomized traffic; a refused requester keeps its request unchanged.
    for (int n = 0; n < 400; n++) begin
      if (!bus.alu_wb_valid || last_ga) begin
        bus.alu_wb_valid = ($urandom_range(0, 99) < 60);
        bus.alu_wb_rd    = 5'($urandom_range(0, 31));
        bus.alu_wb_data  = $urandom;
      end
      if (!bus.lsu_wb_valid || last_gl) begin
        cand.delete();
        for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
        bus.lsu_wb_valid = 0;
        if (cand.size() > 0 && $urandom_range(0, 99) < 60) begin
          bus.lsu_wb_valid = 1;
          bus.lsu_wb_rd    = 5'(cand[$urandom_range(0, cand.size() - 1)]);
          bus.lsu_wb_data  = $urandom;
        end
      end
      bus.ld_issue_valid = ($urandom_range(0, 99) < 40);
      bus.ld_issue_rd    = 5'($urandom_range(0, 7));
      bus.rs1_addr       = 5'($urandom_range(0, 7));
      bus.rs2_addr       = 5'($urandom_range(0, 7));
      bus.flush          = ($urandom_range(0, 99) < 3);
      step("rnd");
    end

    // Async reset in the middle of a grant.
    drive_idle();
    bus.flush = 1;
    step("pre_rst_flush");
    drive_idle();
    bus.ld_issue_valid = 1; bus.ld_issue_rd = 5'd5;
    bus.alu_wb_valid = 1; bus.alu_wb_rd = 5'd6; bus.alu_wb_data = 32'hCAFE_0006;
    step("pre_rst");
    chk("pre_rst.RegWrite", bus.RegWrite, 1'b1);
    bus.ld_issue_valid = 0;
    bus.alu_wb_rd = 5'd8; bus.alu_wb_data = 32'hCAFE_0008;
    #1;
    sys_arstn = 1'b0;
    #1;
    chk("rst_mid.RegWrite", bus.RegWrite, 1'b0);
    chk("rst_mid.w_addr", bus.w_addr, 5'd0);
    chk("rst_mid.w_data", bus.w_data, 32'd0);
    for (int r = 0; r < 32; r++) begin
      bus.rs1_addr = 5'(r);
      #1;
      chk($sformatf("rst_mid.busy%0d", r), bus.rs1_busy, 1'b0);
    end
    drive_idle();
    model_reset();
    @(posedge sys_clk); #1;
    sys_arstn = 1'b1;
    step("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
